// File: rtl/julia_pkg.sv
// Shared constants, fixed-point type and FSM encoding for the Julia escape-time engine.
package julia_pkg;

  localparam int WIDTH    = 32;
  localparam int FRAC     = 28;
  localparam int MAX_ITER = 100;
  localparam int TAG_W    = 19;
  localparam int CNT_W    = $clog2(MAX_ITER + 1);

  typedef logic signed [WIDTH-1:0] fx_t;

  // Escape radius squared, held at WIDTH+1 bits to match the magnitude sum.
  localparam logic [WIDTH:0] ESCAPE_R2 = (WIDTH + 1)'(4) << FRAC;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/fx_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic right shift, low WIDTH bits kept.
module fx_mul #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 28
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] full;

  assign full = (2 * WIDTH)'(a) * (2 * WIDTH)'(b);
  assign p    = WIDTH'(full >>> SHIFT);

endmodule

// File: rtl/julia_iterator.sv
// Single-pixel Julia/Mandelbrot escape-time iterator with valid/ready handshake on both sides.
module julia_iterator
  import julia_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic signed [WIDTH-1:0] z0_re,
  input  logic signed [WIDTH-1:0] z0_im,
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [CNT_W-1:0]        iter_count,
  output logic                    escaped,
  output logic [TAG_W-1:0]        tag_out
);

  state_t state_reg, state_next;

  fx_t zr_reg, zi_reg, cr_reg, ci_reg;
  fx_t sq_re_reg, sq_im_reg, cross_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] iter_reg;
  logic             escaped_reg;
  logic [TAG_W-1:0] tag_reg;

  logic [WIDTH:0]   mag;
  logic             escape;
  logic [CNT_W-1:0] count_inc;
  logic             last_iter;

  fx_t mul_a [3];
  fx_t mul_b [3];
  fx_t mul_p [3];

  assign mul_a[0] = zr_reg;
  assign mul_b[0] = zr_reg;
  assign mul_a[1] = zi_reg;
  assign mul_b[1] = zi_reg;
  assign mul_a[2] = zr_reg;
  assign mul_b[2] = zi_reg;

  // Lane 2 shifts one bit less so it yields 2*zr*zi directly.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mul
      fx_mul #(
        .WIDTH(WIDTH),
        .SHIFT(gi == 2 ? FRAC - 1 : FRAC)
      ) u_mul (
        .a(mul_a[gi]),
        .b(mul_b[gi]),
        .p(mul_p[gi])
      );
    end
  endgenerate

  // Squares are non-negative, so zero-extend them: the sum cannot wrap negative.
  assign mag       = {1'b0, sq_re_reg} + {1'b0, sq_im_reg};
  assign escape    = mag > ESCAPE_R2;
  assign count_inc = count_reg + CNT_W'(1);
  assign last_iter = count_inc == CNT_W'(MAX_ITER);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_valid) state_next = MUL;
      MUL:     state_next = UPDATE;
      UPDATE:  state_next = (escape || last_iter) ? DONE : MUL;
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      zr_reg      <= '0;
      zi_reg      <= '0;
      cr_reg      <= '0;
      ci_reg      <= '0;
      sq_re_reg   <= '0;
      sq_im_reg   <= '0;
      cross_reg   <= '0;
      count_reg   <= '0;
      iter_reg    <= '0;
      escaped_reg <= 1'b0;
      tag_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            zr_reg    <= z0_re;
            zi_reg    <= z0_im;
            cr_reg    <= c_re;
            ci_reg    <= c_im;
            tag_reg   <= tag_in;
            count_reg <= '0;
          end
        end
        MUL: begin
          sq_re_reg <= mul_p[0];
          sq_im_reg <= mul_p[1];
          cross_reg <= mul_p[2];
        end
        UPDATE: begin
          if (escape) begin
            escaped_reg <= 1'b1;
            iter_reg    <= count_reg;
          end else begin
            zr_reg    <= sq_re_reg - sq_im_reg + cr_reg;
            zi_reg    <= cross_reg + ci_reg;
            count_reg <= count_inc;
            if (last_iter) begin
              escaped_reg <= 1'b0;
              iter_reg    <= CNT_W'(MAX_ITER);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready  = state_reg == IDLE;
  assign result_valid = state_reg == DONE;
  assign iter_count   = iter_reg;
  assign escaped      = escaped_reg;
  assign tag_out      = tag_reg;

endmodule

// File: tb/tb_julia_iterator.sv
// Directed bench for julia_iterator: hand-computed orbits, latency, backpressure and async reset.
module tb_julia_iterator;
  import julia_pkg::*;

  logic                    Clk = 1'b0;
  logic                    Reset = 1'b1;
  logic                    start_valid = 1'b0;
  logic                    start_ready;
  logic signed [WIDTH-1:0] z0_re = '0;
  logic signed [WIDTH-1:0] z0_im = '0;
  logic signed [WIDTH-1:0] c_re = '0;
  logic signed [WIDTH-1:0] c_im = '0;
  logic [TAG_W-1:0]        tag_in = '0;
  logic                    result_valid;
  logic                    result_ready = 1'b0;
  logic [CNT_W-1:0]        iter_count;
  logic                    escaped;
  logic [TAG_W-1:0]        tag_out;

  int vectors = 0;
  int miscompares = 0;

  julia_iterator dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .z0_re       (z0_re),
    .z0_im       (z0_im),
    .c_re        (c_re),
    .c_im        (c_im),
    .tag_in      (tag_in),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .iter_count  (iter_count),
    .escaped     (escaped),
    .tag_out     (tag_out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a job at a falling edge; it is accepted on the next rising edge.
  task automatic start_job(input string name, input logic [31:0] zr, input logic [31:0] zi,
                           input logic [31:0] cr, input logic [31:0] ci, input logic [TAG_W-1:0] tg);
    @(negedge Clk);
    z0_re = zr;
    z0_im = zi;
    c_re  = cr;
    c_im  = ci;
    tag_in = tg;
    start_valid = 1'b1;
    check({name, ".start_ready"}, start_ready, 1);
    @(posedge Clk);
    #1 start_valid = 1'b0;
  endtask

  // Latency is the number of rising edges after acceptance until one samples result_valid high.
  task automatic finish_job(input string name, input int exp_iter, input logic exp_esc,
                            input logic [TAG_W-1:0] exp_tag, input int exp_lat, input int hold);
    int m;
    m = 0;
    @(negedge Clk);
    while (!result_valid && m < 400) begin
      @(negedge Clk);
      m++;
    end
    check({name, ".latency"}, m + 1, exp_lat);
    check({name, ".iter_count"}, iter_count, exp_iter);
    check({name, ".escaped"}, escaped, exp_esc);
    check({name, ".tag_out"}, tag_out, exp_tag);
    check({name, ".start_ready_busy"}, start_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check({name, ".hold_valid"}, result_valid, 1);
      check({name, ".hold_iter"}, iter_count, exp_iter);
      check({name, ".hold_esc"}, escaped, exp_esc);
      check({name, ".hold_tag"}, tag_out, exp_tag);
      check({name, ".hold_start_ready"}, start_ready, 0);
    end
    result_ready = 1'b1;
    @(posedge Clk);
    #1 result_ready = 1'b0;
    check({name, ".idle_start_ready"}, start_ready, 1);
    check({name, ".idle_valid"}, result_valid, 0);
    $display("job %s: iter=%0d escaped=%0d tag=%0h latency=%0d", name, iter_count, escaped, tag_out, m + 1);
  endtask

  initial begin
    #3;
    check("reset.result_valid", result_valid, 0);
    check("reset.iter_count", iter_count, 0);
    check("reset.escaped", escaped, 0);
    check("reset.tag_out", tag_out, 0);
    check("reset.start_ready", start_ready, 1);
    @(negedge Clk);
    Reset = 1'b0;

    // z stays at 0 forever: full-length run.
    start_job("zero", 32'h0, 32'h0, 32'h0, 32'h0, 19'h12345);
    finish_job("zero", 100, 1'b0, 19'h12345, 201, 0);

    // |z0|^2 = 9 escapes before any update.
    start_job("z0_out", 32'h3000_0000, 32'h0, 32'h0, 32'h0, 19'h7FFFF);
    finish_job("z0_out", 0, 1'b1, 19'h7FFFF, 3, 0);

    // Orbit 0,1,2,5; magnitude exactly 4 does not escape.
    start_job("c_one", 32'h0, 32'h0, 32'h1000_0000, 32'h0, 19'h00001);
    finish_job("c_one", 3, 1'b1, 19'h00001, 9, 0);

    // z pinned at 2.0, magnitude stays exactly 4.
    start_job("c_m2", 32'h0, 32'h0, 32'hE000_0000, 32'h0, 19'h2AAAA);
    finish_job("c_m2", 100, 1'b0, 19'h2AAAA, 201, 0);

    // Imaginary-only escape with 10 cycles of backpressure.
    start_job("bp", 32'h0, 32'h3000_0000, 32'h0, 32'h0, 19'h0ABCD);
    finish_job("bp", 0, 1'b1, 19'h0ABCD, 3, 10);

    // Back-to-back: c = 0.5+0.5i escapes at count 5 (exercises the cross term).
    start_job("c_half", 32'h0, 32'h0, 32'h0800_0000, 32'h0800_0000, 19'h3C3C3);
    finish_job("c_half", 5, 1'b1, 19'h3C3C3, 13, 0);

    // c = i cycles between -1+i and -i, never escaping.
    start_job("c_i", 32'h0, 32'h0, 32'h0, 32'h1000_0000, 19'h01F0F);
    finish_job("c_i", 100, 1'b0, 19'h01F0F, 201, 0);

    // Load a non-zero result first so reset clearing is visible.
    start_job("pre_rst", 32'h0, 32'h0, 32'h0800_0000, 32'h0800_0000, 19'h44444);
    finish_job("pre_rst", 5, 1'b1, 19'h44444, 13, 0);

    // Abort a long job while in UPDATE; reset acts without a clock edge.
    start_job("abort", 32'h0, 32'h0, 32'h0, 32'h0, 19'h55555);
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("abort.result_valid", result_valid, 0);
    check("abort.iter_count", iter_count, 0);
    check("abort.escaped", escaped, 0);
    check("abort.tag_out", tag_out, 0);
    check("abort.start_ready", start_ready, 1);
    $display("job abort: outputs after async reset iter=%0d tag=%0h", iter_count, tag_out);
    @(negedge Clk);
    Reset = 1'b0;

    start_job("post_rst", 32'h0, 32'h0, 32'h1000_0000, 32'h0, 19'h66666);
    finish_job("post_rst", 3, 1'b1, 19'h66666, 9, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
